bus_valid_ready_fifo: RTL and testbench

Synchronous FIFO stage with valid/ready handshakes on both sides. It sits directly downstream of the bus register slice and absorbs bursts when the consumer stalls. It decouples producer and consumer by DEPTH entries. It has no combinational path from ready_i to ready_o, and none from valid_i to valid_o.

---
 rtl/bus_pkg.sv | 5 +
 rtl/bus_valid_ready_fifo_if.sv | 26 ++
 rtl/bus_fifo_mem.sv | 21 ++
 rtl/bus_valid_ready_fifo.sv | 57 +++++
 tb/tb_bus_valid_ready_fifo.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared payload width and FIFO depth defaults for the bus slice
package bus_pkg;
   localparam int BUS_WIDTH  = 32;
   localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/bus_valid_ready_fifo_if.sv
// bus_valid_ready_fifo_if: producer and consumer handshakes plus status around the FIFO
interface bus_valid_ready_fifo_if
   import bus_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH,
   parameter int DEPTH = FIFO_DEPTH
);
   localparam int AW = $clog2(DEPTH);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] data_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] data_o;
   logic [AW:0]      count_o;
   logic             full_o;
   logic             empty_o;
   modport slave (
      input  valid_i, data_i, ready_i,
      output ready_o, valid_o, data_o, count_o, full_o, empty_o
   );
   modport master (
      output valid_i, data_i, ready_i,
      input  ready_o, valid_o, data_o, count_o, full_o, empty_o
   );
endinterface

// File: rtl/bus_fifo_mem.sv
// bus_fifo_mem: DEPTH x WIDTH storage, synchronous write, asynchronous read
module bus_fifo_mem
   import bus_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   // write port; contents are never reset, occupancy alone decides what is live
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/bus_valid_ready_fifo.sv
// bus_valid_ready_fifo: registered-status valid/ready FIFO with no input-to-output combinational paths
module bus_valid_ready_fifo
   import bus_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH,
   parameter int DEPTH = FIFO_DEPTH
) (
   input logic                   clk,
   input logic                   rst_n,
   bus_valid_ready_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
   logic             push, pop, ptr_full, ptr_empty;
   logic [WIDTH-1:0] rdata;
   assign bus.full_o  = count_q == (AW+1)'(DEPTH);
   assign bus.empty_o = count_q == '0;
   assign bus.ready_o = !bus.full_o;
   assign bus.valid_o = !bus.empty_o;
   assign bus.count_o = count_q;
   assign bus.data_o  = bus.valid_o ? rdata : '0;
   assign push = bus.valid_i && bus.ready_o;
   assign pop  = bus.valid_o && bus.ready_i;
   assign ptr_empty = wr_ptr_q == rd_ptr_q;
   assign ptr_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   // pointers advance on their own handshake; occupancy nets push against pop
   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end
   // state registers; reset discards every stored beat immediately
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   bus_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (bus.data_i),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rdata)
   );
   a_flags_agree: assert property (@(posedge clk) disable iff (!rst_n)
      ptr_full == bus.full_o && ptr_empty == bus.empty_o);
   a_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
      bus.valid_i && !bus.ready_o |=> bus.valid_i && $stable(bus.data_i));
   a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
      bus.valid_o && !bus.ready_i |=> bus.valid_o && $stable(bus.data_o));
endmodule

// File: tb/tb_bus_valid_ready_fifo.sv
// tb_bus_valid_ready_fifo: scoreboard bench with an occupancy model and in-order beat queue
module tb_bus_valid_ready_fifo;
   import bus_pkg::*;
   localparam int W = BUS_WIDTH;
   localparam int D = FIFO_DEPTH;
   logic clk = 0;
   logic rst_n = 0;
   bus_valid_ready_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();
   bus_valid_ready_fifo #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int n_chk = 0;
   int n_fail = 0;
   int m_cnt = 0;
   bit m_push = 0;
   bit m_pop = 0;
   bit stall = 0;
   int rpct = 0;
   logic [W-1:0] prev_data = '0;
   logic [W-1:0] sent_q[$];
   initial forever #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // monitor: compare against the occupancy model and the issued-beat queue, then advance the model
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         m_cnt = 0;
         m_push = 0;
         stall = 0;
         sent_q.delete();
      end else begin
         chk("count_o", bus.count_o, m_cnt);
         chk("valid_o", bus.valid_o, m_cnt > 0);
         chk("ready_o", bus.ready_o, m_cnt < D);
         chk("full_o", bus.full_o, m_cnt == D);
         chk("empty_o", bus.empty_o, m_cnt == 0);
         if (stall) begin
            chk("hold_valid", bus.valid_o, 1);
            chk("hold_data", bus.data_o, prev_data);
         end
         if (!bus.valid_o) chk("idle_data", bus.data_o, 0);
         else if (sent_q.size() == 0) chk("unexpected_beat", bus.valid_o, 0);
         else begin
            chk("data_o", bus.data_o, sent_q[0]);
            if (bus.ready_i) void'(sent_q.pop_front());
         end
         m_push = bus.valid_i && m_cnt < D;
         m_pop = m_cnt > 0 && bus.ready_i;
         m_cnt = m_cnt + int'(m_push) - int'(m_pop);
         stall = bus.valid_o && !bus.ready_i;
         prev_data = bus.data_o;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
      bus.ready_i = $urandom_range(99) < rpct;
   endtask
   // issue n beats; a beat stays on the bus until the model sees it accepted
   task automatic send(input int n, input logic [W-1:0] base, input bit rnd, input int vpct);
      int k = 0;
      while (k < n) begin
         tick();
         if (!bus.valid_i || m_push) begin
            if ($urandom_range(99) < vpct) begin
               bus.valid_i = 1;
               bus.data_i = rnd ? W'($urandom) : base + W'(k);
               sent_q.push_back(bus.data_i);
               k++;
            end else bus.valid_i = 0;
         end
      end
   endtask
   // wait for the pending beat to be accepted and optionally for the FIFO to empty
   task automatic flush(input bit drain);
      int g = 0;
      bit busy = 1;
      while (busy && g < 300) begin
         tick();
         g++;
         if (m_push) bus.valid_i = 0;
         busy = bus.valid_i || (drain && m_cnt != 0);
      end
      chk("flush_timeout", busy, 0);
   endtask
   initial begin
      bus.valid_i = 0;
      bus.ready_i = 0;
      bus.data_i = '0;
      #12;
      chk("rst_count", bus.count_o, 0);
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_ready", bus.ready_o, 1);
      chk("rst_empty", bus.empty_o, 1);
      chk("rst_data", bus.data_o, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      rpct = 0;
      send(5, W'('hA0), 0, 100);
      repeat (3) tick();
      chk("fill_full", bus.full_o, 1);
      chk("fill_ready", bus.ready_o, 0);
      chk("fill_count", bus.count_o, D);
      rpct = 100;
      flush(1);
      send(100, W'(1), 0, 100);
      flush(1);
      send(1, W'('h55), 0, 100);
      flush(1);
      rpct = 0;
      send(3, W'('hC0), 0, 100);
      flush(0);
      chk("pre_rst_count", bus.count_o, 3);
      @(posedge clk);
      #3;
      rst_n = 0;
      #1;
      chk("mid_rst_valid", bus.valid_o, 0);
      chk("mid_rst_ready", bus.ready_o, 1);
      chk("mid_rst_count", bus.count_o, 0);
      chk("mid_rst_data", bus.data_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      rpct = 100;
      repeat (10) tick();
      send(4, W'('hD0), 0, 100);
      flush(1);
      rpct = 50;
      send(5000, '0, 1, 50);
      rpct = 100;
      flush(1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
